// File: rtl/ppu_defs.sv
// Shared definitions for the PPU VRAM responder: register selects, address
// region boundaries, controller state encoding and the address step helper.
package ppu_defs;

  localparam logic [2:0] SEL_PPUSTATUS = 3'd2;
  localparam logic [2:0] SEL_PPUADDR   = 3'd6;
  localparam logic [2:0] SEL_PPUDATA   = 3'd7;

  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND_WR = 2'd1,
    ST_PEND_RD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RGN_PAT = 2'd0,
    RGN_NT  = 2'd1,
    RGN_PAL = 2'd2
  } region_e;

  // Post-access step of the CPU VRAM address; wraps naturally at 14 bits.
  function automatic logic [13:0] vaddr_step(input logic [13:0] a, input logic inc32);
    return a + (inc32 ? 14'd32 : 14'd1);
  endfunction

endpackage

// File: rtl/ppu_vram_decode.sv
// Maps a 14-bit VRAM address to its region, nametable RAM index (mirrored)
// and palette index (with the sprite-backdrop aliases folded onto 0x00..0x0C).
module ppu_vram_decode
  import ppu_defs::*;
#(
  parameter bit MIRROR_V = 1'b1
) (
  input  logic [13:0] a_i,
  output region_e     region_o,
  output logic [10:0] nt_idx_o,
  output logic [4:0]  pal_idx_o
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    region_o  = RGN_PAT;
    pal_idx_o = a_i[4:0];
    if (a_i >= PAL_BASE) begin
      region_o = RGN_PAL;
    end else if (a_i >= NT_BASE) begin
      region_o = RGN_NT;
    end
    if (a_i[4] && (a_i[1:0] == 2'b00)) begin
      pal_idx_o[4] = 1'b0;
    end
    // Computed for every address: a palette address yields the nametable
    // index of the address 0x1000 below it, which the buffered read needs.
    nt_idx_o = MIRROR_V ? a_i[10:0] : {a_i[11], a_i[9:0]};
  end

endmodule

// File: rtl/ppu_vram.sv
// PPU video-memory responder: 2 KB nametable + palette RAM answering PPU
// fetches, plus the CPU-side PPUADDR/PPUDATA path arbitrated behind them.
module ppu_vram
  import ppu_defs::*;
#(
  parameter bit MIRROR_V = 1'b1,
  parameter int NT_AW    = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] ppu_a,
  input  logic        ppu_rd,
  output logic [7:0]  ppu_dout,
  input  logic [2:0]  ri_sel,
  input  logic        ri_wr,
  input  logic        ri_rd,
  input  logic [7:0]  ri_din,
  output logic [7:0]  ri_dout,
  input  logic        inc32,
  output logic        ri_busy
);

  localparam int NT_DEPTH = 1 << NT_AW;

  logic [7:0] nt_mem  [NT_DEPTH];
  logic [5:0] pal_mem [32];

  state_e      state_q, state_d;
  logic [13:0] vaddr_q, vaddr_d;
  logic        toggle_q, toggle_d;
  logic [7:0]  wbuf_q, wbuf_d;
  logic [7:0]  ri_dout_q, ri_dout_d;
  logic [7:0]  rbuf_q;
  logic [7:0]  ppu_dout_q;
  logic        busy_q;

  region_e     p_rgn, v_rgn;
  logic [10:0] p_nt, v_nt;
  logic [4:0]  p_pal, v_pal;
  logic        busy, commit;

  ppu_vram_decode #(.MIRROR_V(MIRROR_V)) u_dec_ppu (
    .a_i      (ppu_a),
    .region_o (p_rgn),
    .nt_idx_o (p_nt),
    .pal_idx_o(p_pal)
  );

  ppu_vram_decode #(.MIRROR_V(MIRROR_V)) u_dec_cpu (
    .a_i      (vaddr_q),
    .region_o (v_rgn),
    .nt_idx_o (v_nt),
    .pal_idx_o(v_pal)
  );

  assign busy   = (state_q != ST_IDLE);
  assign commit = busy && !ppu_rd;

  always_comb begin
    state_d   = state_q;
    vaddr_d   = vaddr_q;
    toggle_d  = toggle_q;
    wbuf_d    = wbuf_q;
    ri_dout_d = ri_dout_q;

    // Commit first so a same-cycle PPUADDR write lands on the stepped address.
    if (commit) begin
      vaddr_d = vaddr_step(vaddr_q, inc32);
      state_d = ST_IDLE;
    end

    if (ri_wr) begin
      unique case (ri_sel)
        SEL_PPUADDR: begin
          if (!toggle_q) vaddr_d[13:8] = ri_din[5:0];
          else           vaddr_d[7:0]  = ri_din;
          toggle_d = !toggle_q;
        end
        SEL_PPUDATA: begin
          if (!busy) begin
            state_d = ST_PEND_WR;
            wbuf_d  = ri_din;
          end
        end
        default: ;
      endcase
    end else if (ri_rd) begin
      ri_dout_d = 8'h00;
      unique case (ri_sel)
        SEL_PPUSTATUS: toggle_d = 1'b0;
        SEL_PPUDATA: begin
          if (!busy) begin
            state_d   = ST_PEND_RD;
            ri_dout_d = (v_rgn == RGN_PAL) ? {2'b00, pal_mem[v_pal]} : rbuf_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q   <= ST_IDLE;
      vaddr_q   <= '0;
      toggle_q  <= 1'b0;
      wbuf_q    <= '0;
      ri_dout_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vaddr_q   <= vaddr_d;
      toggle_q  <= toggle_d;
      wbuf_q    <= wbuf_d;
      ri_dout_q <= ri_dout_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Single RAM read port: a PPU fetch always wins over a pending CPU read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ppu_dout_q <= '0;
      rbuf_q     <= '0;
    end else if (ppu_rd) begin
      unique case (p_rgn)
        RGN_NT:  ppu_dout_q <= nt_mem[p_nt];
        RGN_PAL: ppu_dout_q <= {2'b00, pal_mem[p_pal]};
        default: ppu_dout_q <= 8'h00;
      endcase
    end else if (commit && (state_q == ST_PEND_RD)) begin
      rbuf_q <= (v_rgn == RGN_PAT) ? 8'h00 : nt_mem[v_nt];
    end
  end

  // NOTE: RAM arrays have no reset; their contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (commit && (state_q == ST_PEND_WR)) begin
      if (v_rgn == RGN_NT) begin
        nt_mem[v_nt] <= wbuf_q;
      end else if (v_rgn == RGN_PAL) begin
        pal_mem[v_pal] <= wbuf_q[5:0];
      end
    end
  end

  assign ppu_dout = ppu_dout_q;
  assign ri_dout  = ri_dout_q;
  assign ri_busy  = busy_q;

endmodule

// File: tb/tb_ppu_vram.sv
// Self-checking bench for ppu_vram: a cycle-level behavioural model of the
// VRAM map and CPU access rules, compared every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_ppu_vram;

  localparam bit MIRROR_V = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] ppu_a = '0;
  logic        ppu_rd = 1'b0;
  logic [7:0]  ppu_dout;
  logic [2:0]  ri_sel = '0;
  logic        ri_wr = 1'b0;
  logic        ri_rd = 1'b0;
  logic [7:0]  ri_din = '0;
  logic [7:0]  ri_dout;
  logic        inc32 = 1'b0;
  logic        ri_busy;

  ppu_vram #(.MIRROR_V(MIRROR_V), .NT_AW(11)) dut (
    .clk     (clk),
    .rst     (rst),
    .ppu_a   (ppu_a),
    .ppu_rd  (ppu_rd),
    .ppu_dout(ppu_dout),
    .ri_sel  (ri_sel),
    .ri_wr   (ri_wr),
    .ri_rd   (ri_rd),
    .ri_din  (ri_din),
    .ri_dout (ri_dout),
    .inc32   (inc32),
    .ri_busy (ri_busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mem_m [16384];
  int         vaddr_m = 0;
  bit         tog_m = 1'b0;
  logic [7:0] buf_m = '0;
  int         pend_m = 0;          // 0 none, 1 write, 2 read
  logic [7:0] pdata_m = '0;
  logic [7:0] e_ppu = '0;
  logic [7:0] e_ri = '0;
  bit         e_busy = 1'b0;
  bit         ri_valid = 1'b0;
  bit         was_busy = 1'b0;

  initial begin
    for (int i = 0; i < 16384; i++) mem_m[i] = 8'h00;
  end

  // Canonical storage location of a VRAM address (mirrors and aliases folded).
  function automatic int canon(input int a);
    int p;
    if (a < 'h2000) return a;
    if (a < 'h3F00) begin
      if (MIRROR_V) return 'h2000 + (a % 'h800);
      return 'h2000 + ((a / 'h800) % 2) * 'h400 + (a % 'h400);
    end
    p = a % 32;
    if (p % 4 == 0) p = p % 16;
    return 'h3F00 + p;
  endfunction

  function automatic logic [7:0] read_m(input int a);
    if (a < 'h2000) return 8'h00;
    return mem_m[canon(a)];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vaddr_m = 0; tog_m = 1'b0; buf_m = '0; pend_m = 0;
      e_ppu = '0; e_ri = '0; e_busy = 1'b0; ri_valid = 1'b0;
    end else begin
      was_busy = (pend_m != 0);
      ri_valid = 1'b0;
      if (ppu_rd) e_ppu = read_m(int'(ppu_a));
      if (was_busy && !ppu_rd) begin
        if (pend_m == 1) begin
          if (vaddr_m >= 'h3F00)      mem_m[canon(vaddr_m)] = pdata_m & 8'h3F;
          else if (vaddr_m >= 'h2000) mem_m[canon(vaddr_m)] = pdata_m;
        end else begin
          buf_m = read_m(vaddr_m >= 'h3F00 ? vaddr_m - 'h1000 : vaddr_m);
        end
        vaddr_m = (vaddr_m + (inc32 ? 32 : 1)) % 16384;
        pend_m = 0;
      end
      if (ri_wr) begin
        if (ri_sel == 3'd6) begin
          if (!tog_m) vaddr_m = (vaddr_m % 256) + (int'(ri_din) % 64) * 256;
          else        vaddr_m = (vaddr_m / 256) * 256 + int'(ri_din);
          tog_m = !tog_m;
        end else if (ri_sel == 3'd7 && !was_busy) begin
          pend_m = 1;
          pdata_m = ri_din;
        end
      end else if (ri_rd) begin
        ri_valid = 1'b1;
        e_ri = 8'h00;
        if (ri_sel == 3'd2) tog_m = 1'b0;
        else if (ri_sel == 3'd7 && !was_busy) begin
          e_ri = (vaddr_m >= 'h3F00) ? read_m(vaddr_m) : buf_m;
          pend_m = 2;
        end
      end
      e_busy = (pend_m != 0);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("ppu_dout", ppu_dout, e_ppu);
      check("ri_busy", 8'(ri_busy), 8'(e_busy));
      if (ri_valid) check("ri_dout", ri_dout, e_ri);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ri_busy && n < 40) begin
      tick();
      n++;
    end
    check("idle_wait", 8'(ri_busy), 8'h00);
  endtask

  task automatic wr_nw(input logic [2:0] sel, input logic [7:0] d);
    ri_sel = sel; ri_din = d; ri_wr = 1'b1;
    tick();
    ri_wr = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    wr_nw(sel, d);
    wait_idle();
  endtask

  task automatic rd(input logic [2:0] sel, input logic [7:0] exp, input string name);
    ri_sel = sel; ri_rd = 1'b1;
    tick();
    ri_rd = 1'b0;
    check(name, ri_dout, exp);
    wait_idle();
  endtask

  task automatic fetch(input logic [13:0] a, input logic [7:0] exp, input string name);
    ppu_a = a; ppu_rd = 1'b1;
    tick();
    ppu_rd = 1'b0;
    check(name, ppu_dout, exp);
  endtask

  task automatic set_addr(input logic [13:0] a);
    wr(3'd6, {2'b00, a[13:8]});
    wr(3'd6, a[7:0]);
  endtask

  task automatic poke(input logic [13:0] a, input logic [7:0] d);
    set_addr(a);
    wr(3'd7, d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check("rst_ppu_dout", ppu_dout, 8'h00);
    check("rst_ri_dout", ri_dout, 8'h00);
    check("rst_busy", 8'(ri_busy), 8'h00);
    rst = 1'b1;
    tick();

    // Reset while a write is pending discards it and clears vaddr.
    poke(14'h2108, 8'h99);
    set_addr(14'h2108);
    ppu_a = 14'h0000; ppu_rd = 1'b1;
    wr_nw(3'd7, 8'h55);
    tick();
    check("midop_busy", 8'(ri_busy), 8'h01);
    rst = 1'b0;
    #1;
    check("midop_busy_rst", 8'(ri_busy), 8'h00);
    check("midop_dout_rst", ppu_dout, 8'h00);
    tick();
    ppu_rd = 1'b0;
    rst = 1'b1;
    tick();
    fetch(14'h2108, 8'h99, "midop_not_written");
    wr(3'd6, 8'h21);
    rd(3'd2, 8'h00, "status_read");
    wr(3'd7, 8'h44);
    fetch(14'h2100, 8'h44, "vaddr_low_reset");

    // Write path and single increment.
    poke(14'h2108, 8'h55);
    fetch(14'h2108, 8'h55, "write_path");
    wr(3'd7, 8'h66);
    fetch(14'h2109, 8'h66, "inc1_next");

    // Increment by 32 and vertical mirroring.
    inc32 = 1'b1;
    set_addr(14'h23E0);
    wr(3'd7, 8'hAA);
    wr(3'd7, 8'hBB);
    inc32 = 1'b0;
    fetch(14'h23E0, 8'hAA, "inc32_first");
    fetch(14'h2400, 8'hBB, "inc32_second");
    fetch(14'h2C00, 8'hBB, "mirror_v");

    // Buffered reads from a cleared buffer.
    poke(14'h2000, 8'h11);
    wr(3'd7, 8'h22);
    do_reset();
    set_addr(14'h2000);
    rd(3'd7, 8'h00, "buf_stale");
    rd(3'd7, 8'h11, "buf_first");
    rd(3'd7, 8'h22, "buf_second");

    // Palette alias, direct palette read, buffer loaded from nametable below.
    poke(14'h2F00, 8'h5A);
    poke(14'h3F10, 8'hED);
    fetch(14'h3F00, 8'h2D, "pal_alias_fetch");
    fetch(14'h3F10, 8'h2D, "pal_alias_src");
    set_addr(14'h3F00);
    rd(3'd7, 8'h2D, "pal_read_direct");
    set_addr(14'h2000);
    rd(3'd7, 8'h5A, "pal_buf_under");

    // Contention with held PPU fetches; second access while busy is dropped.
    poke(14'h2151, 8'hC3);
    set_addr(14'h2150);
    ppu_a = 14'h0000; ppu_rd = 1'b1;
    wr_nw(3'd7, 8'h33);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        ri_sel = 3'd7; ri_din = 8'h44; ri_wr = 1'b1;
      end
      tick();
      ri_wr = 1'b0;
      check("contend_busy", 8'(ri_busy), 8'h01);
    end
    ppu_rd = 1'b0;
    tick();
    check("contend_commit", 8'(ri_busy), 8'h00);
    fetch(14'h2150, 8'h33, "contend_write");
    fetch(14'h2151, 8'hC3, "contend_dropped");
    wr(3'd7, 8'h45);
    fetch(14'h2151, 8'h45, "contend_single_inc");

    // PPUSTATUS read between PPUADDR writes restarts the high byte.
    wr(3'd6, 8'h22);
    rd(3'd2, 8'h00, "status_clears");
    wr(3'd6, 8'h23);
    wr(3'd6, 8'h45);
    wr(3'd7, 8'h9C);
    fetch(14'h2345, 8'h9C, "toggle_restart");

    // Unowned selects, pattern space, write-over-read priority.
    rd(3'd3, 8'h00, "other_sel");
    set_addr(14'h1234);
    wr(3'd7, 8'hFF);
    fetch(14'h1234, 8'h00, "pattern_fetch");
    set_addr(14'h2200);
    ri_sel = 3'd7; ri_din = 8'h5C; ri_wr = 1'b1; ri_rd = 1'b1;
    tick();
    ri_wr = 1'b0; ri_rd = 1'b0;
    wait_idle();
    fetch(14'h2200, 8'h5C, "wr_wins");

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_vram.md
Name: ppu_vram

Overview:
- Video-memory responder for the PPU's 14-bit VRAM address bus. Holds 2 KB of nametable RAM and the 32-entry palette RAM, and answers PPU fetches with registered data.
- Also owns the CPU side of VRAM access: PPUADDR ($2006) and PPUDATA ($2007).
  - Two-write address latch.
  - Auto-increment.
  - Buffered reads.
- CPU accesses are arbitrated against PPU fetches through a one-entry pending-operation buffer.

Parameters:
- MIRROR_V, 1, nametable mirroring. 1 = vertical, uses a[10:0]. 0 = horizontal, uses {a[11], a[9:0]}.
- NT_AW, 11, nametable RAM address width (2 KB).

Ports:
- clk  in  1  50MHz system clock
- rst  in  1  asynchronous, active-low reset
- ppu_a  in  14  PPU fetch address
- ppu_rd  in  1  PPU fetch strobe; has priority over CPU for the RAM port
- ppu_dout  out  8  fetch data, valid the cycle after ppu_rd
- ri_sel  in  3  CPU register select (low 3 bits of $2000-$2007)
- ri_wr  in  1  single-cycle CPU write strobe
- ri_rd  in  1  single-cycle CPU read strobe
- ri_din  in  8  CPU write data
- ri_dout  out  8  CPU read data, valid the cycle after ri_rd
- inc32  in  1  PPUCTRL bit 2: increment 32 when set, else 1
- ri_busy  out  1  high while a $2007 operation is pending

Behaviour:
- Reset (rst low, async): all outputs and internal state go to zero. This covers:
  - ppu_dout, ri_dout, ri_busy
  - vaddr[13:0], address toggle, read buffer[7:0]
  - state = IDLE
  - RAM contents are undefined after reset.
- Memory decode, applied to ppu_a and vaddr:
  - 0x0000-0x1FFF: pattern space, not owned here. Reads return 0x00; writes are dropped.
  - 0x2000-0x3EFF: nametable, mirrored per MIRROR_V.
  - 0x3F00-0x3FFF: palette, index a[4:0]. Indices 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C. Entries store 6 bits; bits 7:6 read as 0.
- PPU fetch: ppu_rd high at cycle N gives ppu_dout = mem(ppu_a) at N+1. ppu_dout holds its value when ppu_rd is low.
- PPUSTATUS read (ri_rd, sel=2): clears the toggle; ri_dout=0x00. Status bits are owned elsewhere.
- PPUADDR write (ri_wr, sel=6):
  - toggle=0: vaddr[13:8] = ri_din[5:0].
  - toggle=1: vaddr[7:0] = ri_din.
  - Each write flips the toggle.
- PPUDATA write (ri_wr, sel=7): IDLE -> PEND_WR and captures ri_din.
- PPUDATA read (ri_rd, sel=7): IDLE -> PEND_RD. ri_dout at the next cycle is:
  - the palette value, when vaddr is in 0x3F00-0x3FFF;
  - otherwise the current read buffer.
- State machine IDLE / PEND_WR / PEND_RD:
  - In a PEND state, on the first cycle with ppu_rd low, commit:
    - PEND_WR: write mem(vaddr).
    - PEND_RD: buffer = mem(vaddr), except that palette addresses load the nametable at vaddr-0x1000.
  - On commit: vaddr += (inc32 ? 32 : 1), wrapping modulo 2^14. Return to IDLE.
  - While ppu_rd stays high, the state holds indefinitely.
  - ri_busy = (state != IDLE), registered.
- Simultaneous events:
  - A $2007 access arriving while busy is dropped; no increment occurs.
  - $2006/$2002 accesses while busy are accepted. vaddr changes take effect on the pending commit.
  - ri_wr and ri_rd high together: the write wins.
  - Other ri_sel values: ignored; ri_dout=0x00.
- Reset during a PEND state discards the operation.

Decomposition:
- Shared package ppu_defs holds:
  - register select constants (PPUSTATUS=2, PPUADDR=6, PPUDATA=7);
  - address region boundaries (NT_BASE 14'h2000, PAL_BASE 14'h3F00);
  - the state encoding.
- One sub-module, ppu_vram_decode: combinational address-to-{region, RAM index} mapping, covering nametable mirroring and palette aliasing. It is instantiated twice: once for ppu_a and once for vaddr.

Test Plan:
- Reset mid-operation: release rst, write $2006=0x21, 0x08, write $2007=0x55, assert rst while ri_busy=1 -> ri_busy=0, vaddr=0x0000, and mem(0x2108) is not written.
- Write path: write $2006=0x21, 0x08, write $2007=0x55 with ppu_rd=0 -> after commit, ppu_rd at 0x2108 gives ppu_dout=0x55 next cycle; vaddr=0x2109.
- Increment 32: inc32=1, start at 0x23E0, two $2007 writes 0xAA, 0xBB -> 0x23E0=0xAA, 0x2400=0xBB. With MIRROR_V=1, a PPU read at 0x2C00 returns 0xBB.
- Buffered read: mem(0x2000)=0x11 and mem(0x2001)=0x22; set vaddr=0x2000 and read $2007 three times -> ri_dout = 0x00 (stale), 0x11, 0x22.
- Palette read and aliasing:
  - write $3F10=0xED -> PPU read of 0x3F00 gives 0x2D;
  - $2007 read at 0x3F00 returns 0x2D immediately;
  - the buffer then holds mem(0x2F00).
- Contention and address reset:
  - Hold ppu_rd=1 for 10 cycles during a pending write -> ri_busy stays 1; commit occurs on the first ppu_rd=0 cycle; a second $2007 write during busy is dropped.
  - A $2002 read between two $2006 writes restarts the high-byte phase.
